// File: rtl/key_expand_seq.sv
// Iterative AES key schedule (AES-128/192/256 by NK): one 32-bit schedule word per
// clock, 128-bit round keys streamed as they complete and kept in an indexed table.

module sbox_LUT (
    input  logic [7:0] i_a,
    output logic [7:0] o_s
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign o_s = SBOX[i_a];
endmodule

module key_expand_seq #(
    parameter int NK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [32*NK-1:0]  aes_key,
    output logic              busy,
    output logic              w_valid,
    output logic [5:0]        w_index,
    output logic [31:0]       w_data,
    output logic              rk_valid,
    output logic [3:0]        rk_index,
    output logic [127:0]      rk_data,
    output logic              done,
    output logic              keys_ready,
    input  logic [3:0]        rd_index,
    output logic [127:0]      rd_key
);
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("key_expand_seq: NK must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GEN} state_t;

    state_t               r_state;
    logic [NK-1:0][31:0]  r_win;     // [0] = oldest word w[i-NK], [NK-1] = newest w[i-1]
    logic [5:0]           r_idx;
    logic [2:0]           r_phase;   // r_idx mod NK
    logic [7:0]           r_rcon;
    logic [2:0][31:0]     r_acc;
    logic [127:0]         r_tbl [0:NR];

    logic [NK-1:0][31:0]  w_key;
    logic [5:0]           w_nidx;
    logic [2:0]           w_nphase;
    logic                 w_rot;
    logic [31:0]          w_temp, w_sub_in, w_sub_out, w_gen_t, w_gen, w_nword;
    logic [7:0]           w_xt;
    logic                 w_step;
    logic [127:0]         w_rk;

    assign w_key    = aes_key;  // w[k] sits at w_key[NK-1-k]
    assign w_nidx   = (r_state == S_IDLE) ? 6'd0 : r_idx + 6'd1;
    assign w_nphase = (r_state == S_IDLE || r_phase == 3'(NK - 1)) ? 3'd0 : r_phase + 3'd1;
    assign w_rot    = (w_nphase == 3'd0);
    assign w_temp   = r_win[NK-1];
    assign w_sub_in = w_rot ? {w_temp[23:0], w_temp[31:24]} : w_temp;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sbox_LUT u_sbox (.i_a(w_sub_in[8*g +: 8]), .o_s(w_sub_out[8*g +: 8]));
    end

    assign w_gen_t = w_rot ? (w_sub_out ^ {r_rcon, 24'h0})
                   : (NK == 8 && w_nphase == 3'd4) ? w_sub_out : w_temp;
    assign w_gen   = r_win[0] ^ w_gen_t;
    assign w_nword = (r_state == S_IDLE) ? w_key[NK-1]
                   : (r_state == S_EMIT) ? r_win[0] : w_gen;
    assign w_xt    = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    assign w_step  = (r_state == S_IDLE && start) || (r_state == S_EMIT)
                   || (r_state == S_GEN && r_idx != 6'(NW - 1));
    assign w_rk    = {r_acc[0], r_acc[1], r_acc[2], w_nword};
    assign rd_key  = (rd_index > 4'(NR)) ? 128'h0 : r_tbl[rd_index];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_win      <= '0;
            r_idx      <= '0;
            r_phase    <= '0;
            r_rcon     <= 8'h01;
            r_acc      <= '0;
            busy       <= 1'b0;
            w_valid    <= 1'b0;
            w_index    <= '0;
            w_data     <= '0;
            rk_valid   <= 1'b0;
            rk_index   <= '0;
            rk_data    <= '0;
            done       <= 1'b0;
            keys_ready <= 1'b0;
            for (int r = 0; r <= NR; r++) r_tbl[r] <= '0;
        end else begin
            done     <= 1'b0;
            w_valid  <= 1'b0;
            rk_valid <= 1'b0;
            if (w_step) begin
                w_valid <= 1'b1;
                w_index <= w_nidx;
                w_data  <= w_nword;
                r_idx   <= w_nidx;
                r_phase <= w_nphase;
                if (w_nidx[1:0] == 2'd3) begin
                    rk_valid              <= 1'b1;
                    rk_index              <= w_nidx[5:2];
                    rk_data               <= w_rk;
                    r_tbl[w_nidx[5:2]]    <= w_rk;
                end else begin
                    r_acc[w_nidx[1:0]] <= w_nword;
                end
            end
            case (r_state)
                S_IDLE: if (start) begin
                    r_state    <= S_EMIT;
                    busy       <= 1'b1;
                    keys_ready <= 1'b0;
                    r_rcon     <= 8'h01;
                    // Loaded pre-rotated by one so the NK-1 emit rotations restore w[0..NK-1]
                    for (int k = 0; k < NK; k++) r_win[k] <= w_key[NK-1-((k+1)%NK)];
                end
                S_EMIT: begin
                    r_win <= {r_win[0], r_win[NK-1:1]};
                    if (w_nidx == 6'(NK - 1)) r_state <= S_GEN;
                end
                S_GEN: begin
                    if (r_idx == 6'(NW - 1)) begin
                        r_state    <= S_IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        keys_ready <= 1'b1;
                    end else begin
                        r_win <= {w_gen, r_win[NK-1:1]};
                        if (w_rot) r_rcon <= w_xt;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_expand_seq.sv
// Bench for key_expand_seq: one instance per key size, FIPS-197 vectors, random keys
// against an array-based schedule model, plus start/restart/reset corner sequences.

module tb_key_expand_seq;
    logic               clk = 1'b0;
    logic               rst_n;
    logic [2:0]         start;
    logic [2:0][255:0]  key_in;
    logic [2:0][3:0]    rd_index;
    logic [2:0]         busy, w_valid, rk_valid, done, keys_ready;
    logic [2:0][5:0]    w_index;
    logic [2:0][31:0]   w_data;
    logic [2:0][3:0]    rk_index;
    logic [2:0][127:0]  rk_data, rd_key;

    always #5 clk = ~clk;

    key_expand_seq #(.NK(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .aes_key(key_in[0][255:128]),
        .busy(busy[0]), .w_valid(w_valid[0]), .w_index(w_index[0]), .w_data(w_data[0]),
        .rk_valid(rk_valid[0]), .rk_index(rk_index[0]), .rk_data(rk_data[0]),
        .done(done[0]), .keys_ready(keys_ready[0]), .rd_index(rd_index[0]), .rd_key(rd_key[0]));
    key_expand_seq #(.NK(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .aes_key(key_in[1][255:64]),
        .busy(busy[1]), .w_valid(w_valid[1]), .w_index(w_index[1]), .w_data(w_data[1]),
        .rk_valid(rk_valid[1]), .rk_index(rk_index[1]), .rk_data(rk_data[1]),
        .done(done[1]), .keys_ready(keys_ready[1]), .rd_index(rd_index[1]), .rd_key(rd_key[1]));
    key_expand_seq #(.NK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .aes_key(key_in[2]),
        .busy(busy[2]), .w_valid(w_valid[2]), .w_index(w_index[2]), .w_data(w_data[2]),
        .rk_valid(rk_valid[2]), .rk_index(rk_index[2]), .rk_data(rk_data[2]),
        .done(done[2]), .keys_ready(keys_ready[2]), .rd_index(rd_index[2]), .rd_key(rd_key[2]));

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  sb [256];
    logic [31:0] exp_w [64];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] y = {x, x};
        return y[15-n -: 8];
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8), then the affine map
    function automatic void build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic void model(input int nk, input logic [255:0] key);
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < nk; i++) exp_w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nk+7); i++) begin
            t = exp_w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % 8 == 4) begin
                t = subw(t);
            end
            exp_w[i] = exp_w[i-nk] ^ t;
        end
    endfunction

    // Starts an expansion on instance d and checks every cycle up to the done cycle.
    // Returns while sampling the done cycle, so a following call starts in that cycle.
    task automatic stream(input int d, input logic [255:0] key, input int spur_at, input int kill_at);
        int nk, nr, nw, nwv, nrk;
        nk = 4 + 2*d; nr = nk + 6; nw = 4*(nr + 1); nwv = 0; nrk = 0;
        model(nk, key);
        key_in[d] = key;
        start[d]  = 1'b1;
        for (int c = 1; c <= nw + 1; c++) begin
            @(posedge clk); #1;
            start[d] = 1'b0;
            nwv += int'(w_valid[d]);
            nrk += int'(rk_valid[d]);
            if (c <= nw) chk("w_word", {w_valid[d], w_index[d], w_data[d]}, {1'b1, 6'(c-1), exp_w[c-1]});
            else         chk("w_valid_end", w_valid[d], 0);
            chk("rk_valid", rk_valid[d], (c <= nw) && (c % 4 == 0));
            if (c <= nw && c % 4 == 0) begin
                chk("rk_index", rk_index[d], c/4 - 1);
                chk("rk_data", rk_data[d], {exp_w[c-4], exp_w[c-3], exp_w[c-2], exp_w[c-1]});
            end
            chk("status", {busy[d], done[d], keys_ready[d]}, {c <= nw, c == nw + 1, c == nw + 1});
            if (c - 1 == kill_at) begin
                rst_n = 1'b0; #1;
                chk("arst_out", {busy[d], w_valid[d], w_index[d], w_data[d], rk_valid[d],
                                 rk_index[d], done[d], keys_ready[d]}, 0);
                chk("arst_rk", rk_data[d], 0);
                chk("arst_tbl", rd_key[d], 0);
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_hold", {busy[d], done[d], keys_ready[d], w_valid[d]}, 0);
                end
                rst_n = 1'b1;
                repeat (2) begin
                    @(posedge clk); #1;
                    chk("post_rst", {busy[d], done[d], keys_ready[d], w_valid[d], rk_valid[d]}, 0);
                end
                return;
            end
            if (c - 1 == spur_at) begin
                start[d]  = 1'b1;
                key_in[d] = ~key;
            end
        end
        chk("w_count", nwv, nw);
        chk("rk_count", nrk, nr + 1);
    endtask

    task automatic sweep(input int d);
        int nr = 10 + 2*d;
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            rd_index[d] = 4'(r);
            #1;
            if (r <= nr) chk("rd_key", rd_key[d], {exp_w[4*r], exp_w[4*r+1], exp_w[4*r+2], exp_w[4*r+3]});
            else         chk("rd_key_oob", rd_key[d], 0);
            chk("keys_ready_hold", keys_ready[d], 1);
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        int           d;
        logic [255:0] key;
        int           rkn;
        logic [127:0] rk;
    } vec_t;

    function automatic logic [255:0] rnd_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        vec_t         vecs [3];
        logic [255:0] k1;
        vecs[0] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
                    12, 128'he98ba06f448c773c8ecc720401002202};
        vecs[2] = '{2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                    14, 128'hfe4890d1e6188d0b046df344706c631e};
        build_sbox();

        rst_n = 1'b0; start = '0; key_in = '0; rd_index = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_out", {busy[d], w_valid[d], w_index[d], w_data[d], rk_valid[d],
                            rk_index[d], done[d], keys_ready[d]}, 0);
            chk("rst_rk", rk_data[d], 0);
            chk("rst_rd", rd_key[d], 0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 3; v++) begin
            stream(vecs[v].d, vecs[v].key, -1, -1);
            sweep(vecs[v].d);
            rd_index[vecs[v].d] = 4'(vecs[v].rkn);
            #1;
            chk("fips_last_rk", rd_key[vecs[v].d], vecs[v].rk);
        end

        for (int d = 0; d < 3; d++)
            for (int n = 0; n < 2; n++) begin
                stream(d, rnd_key(), -1, -1);
                sweep(d);
            end

        // start while busy, with a different key, must not disturb the stream
        stream(1, rnd_key(), 20, -1);
        sweep(1);

        // back-to-back: second start issued in the done cycle
        k1 = rnd_key();
        stream(0, k1, -1, -1);
        stream(0, rnd_key(), -1, -1);
        sweep(0);

        // reset mid-expansion, then a fresh full schedule
        rd_index[2] = 4'd0;
        k1 = rnd_key();
        stream(2, k1, -1, 17);
        stream(2, k1, -1, -1);
        sweep(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
